// File: rtl/flash_spi_responder_if.sv
// Serial-flash pins plus the side preload port, bundled between a
// controller (master) and the flash_spi_responder model (slave).
interface flash_spi_responder_if #(
  parameter int MEM_AW = 12
) ();
  logic              FLCK;
  logic              FLRST;
  logic              FLCS;
  logic              FLSO;
  logic              FLSI;
  logic              PWE;
  logic [MEM_AW-1:0] PADDR;
  logic [7:0]        PDATA;

  modport master (
    output FLCK, FLRST, FLCS, FLSO, PWE, PADDR, PDATA,
    input  FLSI
  );

  modport slave (
    input  FLCK, FLRST, FLCS, FLSO, PWE, PADDR, PDATA,
    output FLSI
  );
endinterface

// File: rtl/flash_spi_responder.sv
// Read-only SPI NOR flash responder (mode 0) backed by a preloadable byte
// array; oversamples the SPI pins with the system clock CLKH.
module flash_spi_responder #(
  parameter int         MEM_AW  = 12,
  parameter logic [7:0] STATUS1 = 8'h00,
  parameter logic [7:0] STATUS2 = 8'h02,
  parameter logic [7:0] STATUS3 = 8'h60,
  parameter logic [7:0] MFR_ID  = 8'hEF,
  parameter logic [7:0] DEV_ID  = 8'h17
) (
  input  logic                  CLKH,
  input  logic                  RESET,
  flash_spi_responder_if.slave  bus,
  output logic                  CMD_STB,
  output logic [7:0]            CMD_CODE
);

  localparam logic [7:0] C_READ  = 8'h03;
  localparam logic [7:0] C_FAST  = 8'h0B;
  localparam logic [7:0] C_RDSR1 = 8'h05;
  localparam logic [7:0] C_RDSR2 = 8'h35;
  localparam logic [7:0] C_RDSR3 = 8'h15;
  localparam logic [7:0] C_RDID  = 8'h90;
  localparam logic [7:0] C_RES   = 8'hAB;
  localparam logic [7:0] C_RUID  = 8'h4B;
  localparam logic [7:0] C_SFDP  = 8'h5A;
  localparam logic [7:0] C_RDSEC = 8'h48;

  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_t;

  function automatic logic has_addr(input logic [7:0] c);
    return c inside {C_READ, C_FAST, C_RDID, C_RES, C_RUID, C_SFDP, C_RDSEC};
  endfunction

  function automatic logic has_dummy(input logic [7:0] c);
    return c inside {C_FAST, C_RUID, C_SFDP, C_RDSEC};
  endfunction

  function automatic logic is_status(input logic [7:0] c);
    return c inside {C_RDSR1, C_RDSR2, C_RDSR3};
  endfunction

  state_t            r_state;
  state_t            w_next_state;

  logic              r_flck;
  logic              r_flck_d;
  logic              r_flcs;
  logic              r_flso;
  logic              r_flrst;

  logic [4:0]        r_bit_cnt;
  logic [6:0]        r_cmd_sh;
  logic [7:0]        r_cmd_code;
  logic              r_cmd_stb;
  logic [MEM_AW-1:0] r_addr;
  logic [6:0]        r_tx;
  logic              r_flsi;

  logic [7:0]        r_mem [0:(1<<MEM_AW)-1];
  logic [7:0]        r_rdata;

  logic              w_rise;
  logic              w_fall;
  logic              w_abort;
  logic [7:0]        w_cmd_byte;
  logic [MEM_AW-1:0] w_addr_in;
  logic [MEM_AW-1:0] w_next_addr;
  logic [MEM_AW-1:0] w_rd_addr;
  logic              w_cmd_done;
  logic              w_addr_done;
  logic              w_dummy_done;
  logic              w_byte_start;
  logic              w_rd_en;
  logic [7:0]        w_src_byte;

  // Pin synchronisers; FLCK edges come from the registered copy and its delay.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLKH or negedge RESET) begin
    if (!RESET) begin
      r_flck   <= 1'b0;
      r_flck_d <= 1'b0;
      r_flcs   <= 1'b1;
      r_flso   <= 1'b0;
      r_flrst  <= 1'b0;
    end else begin
      r_flck   <= bus.FLCK;
      r_flck_d <= r_flck;
      r_flcs   <= bus.FLCS;
      r_flso   <= bus.FLSO;
      r_flrst  <= bus.FLRST;
    end
  end

  assign w_rise       = r_flck & ~r_flck_d;
  assign w_fall       = ~r_flck & r_flck_d;
  assign w_abort      = r_flcs | ~r_flrst;
  assign w_cmd_byte   = {r_cmd_sh, r_flso};
  assign w_addr_in    = {r_addr[MEM_AW-2:0], r_flso};
  assign w_next_addr  = r_addr + ADDR_ONE;

  assign w_cmd_done   = !w_abort && (r_state == S_CMD)   && w_rise && (r_bit_cnt == 5'd7);
  assign w_addr_done  = !w_abort && (r_state == S_ADDR)  && w_rise && (r_bit_cnt == 5'd23);
  assign w_dummy_done = !w_abort && (r_state == S_DUMMY) && w_rise && (r_bit_cnt == 5'd7);
  assign w_byte_start = !w_abort && (r_state == S_DATA)  && w_fall && (r_bit_cnt == 5'd0);

  // First byte is fetched on the last address edge so it is ready at the very
  // next FLCK fall; later bytes are fetched as the previous one starts shifting.
  assign w_rd_en   = w_addr_done | w_byte_start;
  assign w_rd_addr = w_addr_done ? w_addr_in : w_next_addr;

  // NOTE: the array and its read register carry no reset; contents must survive RESET.
  always_ff @(posedge CLKH) begin
    if (bus.PWE) begin
      r_mem[bus.PADDR] <= bus.PDATA;
    end
    if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge CLKH or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_CMD;
        S_CMD: begin
          if (w_cmd_done) begin
            if (has_addr(w_cmd_byte)) begin
              w_next_state = S_ADDR;
            end else if (is_status(w_cmd_byte)) begin
              w_next_state = S_DATA;
            end else begin
              w_next_state = S_IGNORE;
            end
          end
        end
        S_ADDR: begin
          if (w_addr_done) begin
            w_next_state = has_dummy(r_cmd_code) ? S_DUMMY : S_DATA;
          end
        end
        S_DUMMY: begin
          if (w_dummy_done) begin
            w_next_state = S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // The 90h ID pair alternates because the byte address steps every byte.
  always_comb begin
    w_src_byte = 8'hFF;
    case (r_cmd_code)
      C_READ, C_FAST: w_src_byte = r_rdata;
      C_RDSR1:        w_src_byte = STATUS1;
      C_RDSR2:        w_src_byte = STATUS2;
      C_RDSR3:        w_src_byte = STATUS3;
      C_RDID:         w_src_byte = r_addr[0] ? DEV_ID : MFR_ID;
      C_RES:          w_src_byte = DEV_ID;
      default:        w_src_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge CLKH or negedge RESET) begin
    if (!RESET) begin
      r_bit_cnt  <= '0;
      r_cmd_sh   <= '0;
      r_cmd_code <= 8'h00;
      r_cmd_stb  <= 1'b0;
      r_addr     <= '0;
      r_tx       <= '0;
      r_flsi     <= 1'b1;
    end else begin
      r_cmd_stb <= w_cmd_done;
      if (w_abort) begin
        r_bit_cnt <= '0;
        r_flsi    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_CMD: begin
            if (w_rise) begin
              r_cmd_sh <= w_cmd_byte[6:0];
              if (w_cmd_done) begin
                r_bit_cnt  <= '0;
                r_cmd_code <= w_cmd_byte;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_addr    <= w_addr_in;
              r_bit_cnt <= w_addr_done ? 5'd0 : r_bit_cnt + 5'd1;
            end
          end
          S_DUMMY: begin
            if (w_rise) begin
              r_bit_cnt <= w_dummy_done ? 5'd0 : r_bit_cnt + 5'd1;
            end
          end
          S_DATA: begin
            if (w_fall) begin
              if (w_byte_start) begin
                r_flsi <= w_src_byte[7];
                r_tx   <= w_src_byte[6:0];
                r_addr <= w_next_addr;
              end else begin
                r_flsi <= r_tx[6];
                r_tx   <= {r_tx[5:0], 1'b0};
              end
              r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
            end
          end
          S_IGNORE: r_flsi <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.FLSI = r_flsi;
  assign CMD_STB  = r_cmd_stb;
  assign CMD_CODE = r_cmd_code;

endmodule

// File: tb/tb_flash_spi_responder.sv
// Directed bench for flash_spi_responder: stimulus queues expected bytes and
// command codes, independent monitors compare what the responder presents.
module tb_flash_spi_responder;

  logic       clk;
  logic       rst_n;
  logic       cmd_stb;
  logic [7:0] cmd_code;

  flash_spi_responder_if #(.MEM_AW(12)) bus ();

  flash_spi_responder #(.MEM_AW(12)) dut (
    .CLKH     (clk),
    .RESET    (rst_n),
    .bus      (bus),
    .CMD_STB  (cmd_stb),
    .CMD_CODE (cmd_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         h        = 2;
  logic       rx_en    = 1'b0;
  logic [7:0] exp_bytes [$];
  logic [7:0] exp_cmds  [$];
  logic [7:0] rx_sh;
  int         rx_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Byte monitor: the controller samples FLSI on its own rising FLCK edges.
  always @(posedge bus.FLCK) begin
    if (rx_en) begin
      rx_sh = {rx_sh[6:0], bus.FLSI};
      rx_cnt++;
      if (rx_cnt == 8) begin
        rx_cnt = 0;
        if (exp_bytes.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_byte_unexpected: got %0h, required no byte", rx_sh);
        end else begin
          check("rx_byte", 32'(rx_sh), 32'(exp_bytes.pop_front()));
        end
      end
    end else begin
      rx_cnt = 0;
    end
  end

  // Command monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (cmd_stb === 1'b1) begin
      if (exp_cmds.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmd_stb_unexpected: got code %0h, required no strobe", cmd_code);
      end else begin
        check("cmd_code", 32'(cmd_code), 32'(exp_cmds.pop_front()));
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.PWE   = 1'b1;
    bus.PADDR = a;
    bus.PDATA = d;
    @(negedge clk);
    bus.PWE   = 1'b0;
  endtask

  task automatic spi_bit(input logic b);
    bus.FLSO = b;
    repeat (h) @(negedge clk);
    bus.FLCK = 1'b1;
    repeat (h) @(negedge clk);
    bus.FLCK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.FLCS = 1'b0;
  endtask

  task automatic cs_high();
    repeat (h) @(negedge clk);
    bus.FLCS = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_bytes(input int n);
    rx_en = 1'b1;
    repeat (n * 8) spi_bit(1'b0);
    rx_en = 1'b0;
  endtask

  task automatic tx(input logic [7:0] cmd, input bit with_addr, input logic [23:0] a,
                    input int n_dummy, input int n_rx);
    cs_low();
    spi_byte(cmd);
    if (with_addr) begin
      spi_byte(a[23:16]);
      spi_byte(a[15:8]);
      spi_byte(a[7:0]);
    end
    repeat (n_dummy) spi_bit(1'b0);
    rx_bytes(n_rx);
    cs_high();
  endtask

  task automatic expect_bytes(input logic [7:0] c, input logic [31:0] b, input int n);
    logic [31:0] v;
    v = b;
    exp_cmds.push_back(c);
    for (int i = 0; i < n; i++) begin
      exp_bytes.push_back(v[31:24]);
      v = v << 8;
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #400000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    summary();
    $finish;
  end

  initial begin
    logic [7:0] part;
    rst_n     = 1'b0;
    bus.FLCK  = 1'b0;
    bus.FLCS  = 1'b1;
    bus.FLSO  = 1'b0;
    bus.FLRST = 1'b1;
    bus.PWE   = 1'b0;
    bus.PADDR = '0;
    bus.PDATA = '0;
    repeat (3) @(negedge clk);
    check("reset_flsi", 32'(bus.FLSI), 32'h1);
    check("reset_cmd_stb", 32'(cmd_stb), 32'h0);
    check("reset_cmd_code", 32'(cmd_code), 32'h00);
    rst_n = 1'b1;

    preload(12'h010, 8'hA5);
    preload(12'h011, 8'h3C);
    preload(12'hFFF, 8'h11);
    preload(12'h000, 8'h22);
    preload(12'h020, 8'h01);
    preload(12'h021, 8'h02);
    preload(12'h022, 8'h03);
    preload(12'h023, 8'h04);

    expect_bytes(8'h03, 32'hA53C_0000, 2);
    tx(8'h03, 1'b1, 24'h000010, 0, 2);

    expect_bytes(8'h0B, 32'h1122_0000, 2);
    tx(8'h0B, 1'b1, 24'h000FFF, 8, 2);

    h = 3;
    expect_bytes(8'h05, 32'h0000_0000, 3);
    tx(8'h05, 1'b0, 24'h0, 0, 3);
    expect_bytes(8'h35, 32'h0200_0000, 1);
    tx(8'h35, 1'b0, 24'h0, 0, 1);
    expect_bytes(8'h15, 32'h6000_0000, 1);
    tx(8'h15, 1'b0, 24'h0, 0, 1);
    h = 2;

    expect_bytes(8'h90, 32'h17EF_0000, 2);
    tx(8'h90, 1'b1, 24'h000001, 0, 2);
    expect_bytes(8'h90, 32'hEF17_0000, 2);
    tx(8'h90, 1'b1, 24'h000000, 0, 2);
    expect_bytes(8'hAB, 32'h1717_0000, 2);
    tx(8'hAB, 1'b1, 24'h000000, 0, 2);
    expect_bytes(8'h4B, 32'hFF00_0000, 1);
    tx(8'h4B, 1'b1, 24'h000000, 8, 1);

    // Command abandoned after 5 bits, then a clean read.
    part = 8'h0B;
    cs_low();
    for (int i = 7; i >= 3; i--) spi_bit(part[i]);
    cs_high();
    expect_bytes(8'h03, 32'hA53C_0000, 2);
    tx(8'h03, 1'b1, 24'h000010, 0, 2);

    // Unknown command at the fastest FLCK rate: output stays high.
    h = 1;
    expect_bytes(8'h9F, 32'hFFFF_0000, 2);
    tx(8'h9F, 1'b0, 24'h0, 0, 2);
    h = 2;

    // Preload write mid-transaction lands before that byte is fetched.
    expect_bytes(8'h03, 32'h0102_0399, 4);
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_byte(8'h00);
    spi_byte(8'h20);
    rx_bytes(1);
    preload(12'h023, 8'h99);
    rx_bytes(3);
    cs_high();

    // Device reset during data: idle output, command code kept.
    expect_bytes(8'h03, 32'hA500_0000, 1);
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_byte(8'h00);
    spi_byte(8'h10);
    rx_bytes(1);
    bus.FLRST = 1'b0;
    repeat (3) @(negedge clk);
    check("flrst_flsi", 32'(bus.FLSI), 32'h1);
    check("flrst_cmd_code", 32'(cmd_code), 32'h03);
    bus.FLRST = 1'b1;
    cs_high();

    // Asynchronous RESET in the middle of a data byte (FLSI is 0 here).
    exp_cmds.push_back(8'h03);
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_byte(8'h00);
    spi_byte(8'h10);
    repeat (4) spi_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_flsi", 32'(bus.FLSI), 32'h1);
    check("async_reset_cmd_code", 32'(cmd_code), 32'h00);
    @(negedge clk);
    bus.FLCS = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_bytes(8'h03, 32'hA53C_0000, 2);
    tx(8'h03, 1'b1, 24'h000010, 0, 2);

    repeat (5) @(negedge clk);
    check("exp_bytes_drained", 32'(exp_bytes.size()), 32'h0);
    check("exp_cmds_drained", 32'(exp_cmds.size()), 32'h0);
    summary();
    $finish;
  end

endmodule

// File: doc/flash_spi_responder.md
FLASH_SPI_RESPONDER -- requirements
Module: flash_spi_responder

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 12, meaning the byte-address width of the internal array (2^MEM_AW bytes).
REQ-002 The block SHALL have parameter STATUS1, default 8'h00, meaning the value returned for command 05h.
REQ-003 The block SHALL have parameter STATUS2, default 8'h02, meaning the value returned for command 35h.
REQ-004 The block SHALL have parameter STATUS3, default 8'h60, meaning the value returned for command 15h.
REQ-005 The block SHALL have parameter MFR_ID, default 8'hEF, meaning the manufacturer ID.
REQ-006 The block SHALL have parameter DEV_ID, default 8'h17, meaning the device ID.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset: CLKH input 1 is the system clock, rising edge; RESET input 1 is the asynchronous active-low reset.
REQ-008 The block SHALL have port FLCK, input, 1 bit: SPI clock from the controller, low when idle.
REQ-009 The block SHALL have port FLRST, input, 1 bit: device reset, active low, sampled synchronously.
REQ-010 The block SHALL have port FLCS, input, 1 bit: chip select, active low.
REQ-011 The block SHALL have port FLSO, input, 1 bit: serial data from the controller, MSB first.
REQ-012 The block SHALL have port FLSI, output, 1 bit: serial data to the controller, MSB first.
REQ-013 The block SHALL have port PWE, input, 1 bit: preload write strobe.
REQ-014 The block SHALL have port PADDR, input, MEM_AW bits: preload byte address.
REQ-015 The block SHALL have port PDATA, input, 8 bits: preload byte.
REQ-016 The block SHALL have port CMD_STB, output, 1 bit: one-cycle pulse when a command byte completes.
REQ-017 The block SHALL have port CMD_CODE, output, 8 bits: the last received command byte.

Function
REQ-018 FLCK, FLCS and FLSO SHALL be registered once; rising and falling edges SHALL be detected from the registered FLCK and its previous value, and the block SHALL support FLCK half-periods of 1 or more CLKH cycles.
REQ-019 Input bits SHALL be sampled on detected FLCK rising edges; FLSI SHALL change only on detected falling edges or on FLCS going high.
REQ-020 The state machine SHALL have the states IDLE, CMD, ADDR, DUMMY, DATA and IGNORE.
REQ-021 FLCS high SHALL force IDLE, clear the bit counters and set FLSI=1 regardless of state, including mid-byte.
REQ-022 When FLCS is low in IDLE, the block SHALL enter CMD; after 8 rising edges it SHALL latch CMD_CODE and pulse CMD_STB in the following cycle.
REQ-023 Command decode: 03h SHALL go CMD->ADDR->DATA, reading the array.
REQ-024 Command decode: 0Bh SHALL go CMD->ADDR->DUMMY (8 clocks)->DATA, reading the array.
REQ-025 Command decode: 05h/35h/15h SHALL go CMD->DATA and repeat STATUS1/2/3 respectively.
REQ-026 Command decode: 90h SHALL go CMD->ADDR->DATA and alternate MFR_ID, DEV_ID, starting with DEV_ID when addr[0]=1.
REQ-027 Command decode: ABh SHALL go CMD->ADDR->DATA and repeat DEV_ID.
REQ-028 Command decode: 4Bh/5Ah/48h SHALL go CMD->ADDR->DUMMY->DATA and return FFh.
REQ-029 Command decode: any other command SHALL go to IGNORE with FLSI=1 until FLCS goes high.
REQ-030 ADDR SHALL shift in 24 bits MSB first; only the low MEM_AW bits SHALL index the array.
REQ-031 In DATA, bit 7 of the first byte SHALL be driven on the falling edge following the last ADDR, DUMMY or CMD rising edge, with successive bits on successive falling edges.
REQ-032 The next byte SHALL be fetched before its bit 7 is due, and the address SHALL increment per byte, wrapping from 2^MEM_AW-1 to 0.
REQ-033 Array reads SHALL be synchronous, 1-cycle latency.
REQ-034 PWE=1 SHALL write PDATA to PADDR in any state.
REQ-035 When a preload write and a DATA fetch target the same address in the same cycle, the fetch SHALL return the old byte.
REQ-036 FLRST low SHALL act like FLCS high (IDLE, FLSI=1) without altering the array or CMD_CODE.
REQ-037 There SHALL be no write or erase commands; FLSO is ignored in DATA.

Reset
REQ-038 RESET low SHALL asynchronously force IDLE, FLSI=1, CMD_STB=0, CMD_CODE=00h, and clear counters and the address register.
REQ-039 Array contents SHALL NOT be reset.
REQ-040 The block SHALL leave reset in IDLE and treat the first FLCS-low period as a new transaction.

Verification
REQ-041 Preload mem[010h]=A5h, mem[011h]=3Ch; send 03h,00h,00h,10h, then 16 clocks -> FLSI bits A5h then 3Ch; CMD_STB pulses once with CMD_CODE=03h.
REQ-042 Send 0Bh,00h,0Fh,FFh + 8 dummy clocks, mem[FFFh]=11h, mem[000h]=22h -> 11h then 22h (wrap).
REQ-043 Send 05h then 24 clocks -> STATUS1 repeated three times; 35h -> 02h.
REQ-044 Send 90h,00h,00h,01h then 16 clocks -> 17h then EFh; with addr 000000h -> EFh then 17h.
REQ-045 Raise FLCS after 5 bits of a command, then send a full 03h read -> correct data; an unknown command 9Fh -> FLSI held 1.
REQ-046 Assert RESET during DATA -> FLSI=1 and CMD_CODE=00h immediately; after release, a 03h read returns the preloaded data unchanged.
